// File: rtl/cacheline_burst_adaptor.sv
// Purpose: turns one 256-bit cache line read/write into a 4-beat 64-bit memory
//          burst, and reassembles read beats into a line for the cache.
// Latency: request accepted in IDLE -> mem_read_o/mem_write_o next cycle;
//          line_resp_o one cycle after the 4th beat (5 cycles minimum).
// Backpressure: memory paces the burst with mem_resp_i, one beat per high
//          cycle; beats may be non-consecutive.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   line_read_i/line_write_i  cache line request, held until line_resp_o
//   line_address_i            line address (bits [4:0] ignored)
//   line_wdata_i/line_rdata_o line write data / assembled read line
//   line_resp_o               one-cycle completion pulse
//   mem_read_o/mem_write_o    burst request to memory
//   mem_address_o             line-aligned burst address
//   mem_burst_o/mem_burst_i   write beat out / read beat in
//   mem_resp_i                one beat transferred this cycle
module cacheline_burst_adaptor #(
  parameter int S_LINE = 256,
  parameter int S_BEAT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [31:0]       line_address_i,
  input  logic [S_LINE-1:0] line_wdata_i,
  output logic [S_LINE-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_address_o,
  output logic [S_BEAT-1:0] mem_burst_o,
  input  logic [S_BEAT-1:0] mem_burst_i,
  input  logic              mem_resp_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        count;
  logic [31:0]       address;
  logic [S_LINE-1:0] buffer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 2'd0;
      address <= 32'd0;
      buffer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write has priority when the cache raises both requests.
          if (line_write_i) begin
            address <= {line_address_i[31:5], 5'b0};
            buffer  <= line_wdata_i;
            count   <= 2'd0;
            state   <= WRITE;
          end else if (line_read_i) begin
            address <= {line_address_i[31:5], 5'b0};
            count   <= 2'd0;
            state   <= READ;
          end
        end
        READ: begin
          if (mem_resp_i) begin
            buffer[S_BEAT*count +: S_BEAT] <= mem_burst_i;
            count <= count + 2'd1;  // wraps to 0 after the last beat
            if (count == 2'd3) state <= RESP;
          end
        end
        WRITE: begin
          if (mem_resp_i) begin
            count <= count + 2'd1;
            if (count == 2'd3) state <= RESP;
          end
        end
        default: state <= IDLE;  // RESP: requests deliberately not sampled
      endcase
    end
  end

  // Moore outputs: decoded from registered state only.
  assign mem_read_o    = (state == READ);
  assign mem_write_o   = (state == WRITE);
  assign line_resp_o   = (state == RESP);
  assign mem_address_o = address;
  assign line_rdata_o  = buffer;
  assign mem_burst_o   = buffer[S_BEAT*count +: S_BEAT];

endmodule
